// File: rtl/sao_stat_one_block_4x4.sv
// SAO edge-offset statistics front end: per-sample edge signs and saturated
// original-minus-reconstructed difference for one 4x4 block per cycle.
module sao_stat_one_block_4x4 #(
  parameter int unsigned bit_depth = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic        [bit_depth-1:0] rec_l  [0:3][0:3],
  input  logic        [bit_depth-1:0] rec_r  [0:3][0:3],
  input  logic        [bit_depth-1:0] rec_m  [0:3][0:3],
  input  logic        [bit_depth-1:0] org_m  [0:3][0:3],
  output logic                        out_valid,
  output logic signed [1:0]           sign_l [0:3][0:3],
  output logic signed [1:0]           sign_r [0:3][0:3],
  output logic signed [4:0]           diff   [0:3][0:3]
);

  localparam int unsigned dw = bit_depth + 1;
  localparam int unsigned sw = 2;
  localparam int unsigned ow = 5;
  localparam logic signed [dw-1:0] diff_max = dw'(15);
  localparam logic signed [dw-1:0] diff_min = dw'(-16);

  // Three-way compare of centre against one neighbour: +1, 0 or -1.
  function automatic logic signed [sw-1:0] edge_sign(
    input logic [bit_depth-1:0] c,
    input logic [bit_depth-1:0] n
  );
    if (c > n) begin
      edge_sign = 2'sb01;
    end else if (c < n) begin
      edge_sign = 2'sb11;
    end else begin
      edge_sign = 2'sb00;
    end
  endfunction

  // Exact difference at one extra bit, then clamp into the 5-bit output range.
  function automatic logic signed [ow-1:0] sat_diff(
    input logic [bit_depth-1:0] o,
    input logic [bit_depth-1:0] r
  );
    logic signed [dw-1:0] d;
    d = $signed({1'b0, o}) - $signed({1'b0, r});
    if (d > diff_max) begin
      sat_diff = 5'sb01111;
    end else if (d < diff_min) begin
      sat_diff = 5'sb10000;
    end else begin
      sat_diff = d[ow-1:0];
    end
  endfunction

  logic signed [sw-1:0] sign_l_c [0:3][0:3];
  logic signed [sw-1:0] sign_r_c [0:3][0:3];
  logic signed [ow-1:0] diff_c   [0:3][0:3];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        sign_l_c[i][j] = edge_sign(rec_m[i][j], rec_l[i][j]);
        sign_r_c[i][j] = edge_sign(rec_m[i][j], rec_r[i][j]);
        diff_c[i][j]   = sat_diff(org_m[i][j], rec_m[i][j]);
      end
    end
  end

  // Output register: data loads only on valid input and holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          sign_l[i][j] <= '0;
          sign_r[i][j] <= '0;
          diff[i][j]   <= '0;
        end
      end
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) begin
            sign_l[i][j] <= sign_l_c[i][j];
            sign_r[i][j] <= sign_r_c[i][j];
            diff[i][j]   <= diff_c[i][j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sao_stat_one_block_4x4.sv
// Self-checking bench for sao_stat_one_block_4x4 against an integer reference model.
module tb_sao_stat_one_block_4x4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic        [7:0] rec_l  [0:3][0:3];
  logic        [7:0] rec_r  [0:3][0:3];
  logic        [7:0] rec_m  [0:3][0:3];
  logic        [7:0] org_m  [0:3][0:3];
  logic              out_valid;
  logic signed [1:0] sign_l [0:3][0:3];
  logic signed [1:0] sign_r [0:3][0:3];
  logic signed [4:0] diff   [0:3][0:3];

  integer exp_sl [0:3][0:3];
  integer exp_sr [0:3][0:3];
  integer exp_df [0:3][0:3];
  integer errors;
  integer checks;

  sao_stat_one_block_4x4 #(.bit_depth(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .rec_l(rec_l), .rec_r(rec_r), .rec_m(rec_m), .org_m(org_m),
    .out_valid(out_valid), .sign_l(sign_l), .sign_r(sign_r), .diff(diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rules on plain integers.
  function automatic integer ref_sign(input integer c, input integer n);
    if (c > n) return 1;
    if (c < n) return -1;
    return 0;
  endfunction

  function automatic integer ref_diff(input integer o, input integer r);
    integer d;
    d = o - r;
    if (d > 15) return 15;
    if (d < -16) return -16;
    return d;
  endfunction

  task automatic model_block();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        exp_sl[i][j] = ref_sign(integer'(rec_m[i][j]), integer'(rec_l[i][j]));
        exp_sr[i][j] = ref_sign(integer'(rec_m[i][j]), integer'(rec_r[i][j]));
        exp_df[i][j] = ref_diff(integer'(org_m[i][j]), integer'(rec_m[i][j]));
      end
  endtask

  task automatic fill_all(input int l, input int r, input int m, input int o);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        rec_l[i][j] = 8'(l);
        rec_r[i][j] = 8'(r);
        rec_m[i][j] = 8'(m);
        org_m[i][j] = 8'(o);
      end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int m;
        m = int'($urandom_range(0, 255));
        rec_m[i][j] = 8'(m);
        if ($urandom_range(0, 1) == 1) begin
          rec_l[i][j] = 8'($urandom_range(0, 255));
          rec_r[i][j] = 8'($urandom_range(0, 255));
          org_m[i][j] = 8'($urandom_range(0, 255));
        end else begin
          rec_l[i][j] = 8'((m + int'($urandom_range(0, 4)) - 2) & 255);
          rec_r[i][j] = 8'((m + int'($urandom_range(0, 4)) - 2) & 255);
          org_m[i][j] = 8'((m + int'($urandom_range(0, 50)) - 25) & 255);
        end
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    integer g;
    rst_n = 1'b0;
    in_valid = 1'b1;
    fill_all(10, 200, 90, 250);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset out_valid got %b want 0", out_valid);
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        g = sign_l[i][j]; checks++;
        if (g !== 0) begin errors++; $display("FAIL reset sign_l[%0d][%0d] got %0d want 0", i, j, g); end
        g = sign_r[i][j]; checks++;
        if (g !== 0) begin errors++; $display("FAIL reset sign_r[%0d][%0d] got %0d want 0", i, j, g); end
        g = diff[i][j]; checks++;
        if (g !== 0) begin errors++; $display("FAIL reset diff[%0d][%0d] got %0d want 0", i, j, g); end
      end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_uniform();
    integer g;
    in_valid = 1'b1;
    fill_all(222, 221, 223, 225);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL uniform out_valid got %b want 1", out_valid); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        g = sign_l[i][j]; checks++;
        if (g !== 1) begin errors++; $display("FAIL uniform sign_l[%0d][%0d] got %0d want 1", i, j, g); end
        g = sign_r[i][j]; checks++;
        if (g !== 1) begin errors++; $display("FAIL uniform sign_r[%0d][%0d] got %0d want 1", i, j, g); end
        g = diff[i][j]; checks++;
        if (g !== 2) begin errors++; $display("FAIL uniform diff[%0d][%0d] got %0d want 2", i, j, g); end
      end
  endtask

  task automatic test_signs();
    integer g;
    integer want_l [0:1];
    integer want_r [0:1];
    want_l[0] = -1; want_r[0] = 0;
    want_l[1] = 0;  want_r[1] = -1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      if (k == 0) fill_all(150, 100, 100, 100);
      else        fill_all(100, 150, 100, 100);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          g = sign_l[i][j]; checks++;
          if (g !== want_l[k]) begin errors++; $display("FAIL signs%0d sign_l[%0d][%0d] got %0d want %0d", k, i, j, g, want_l[k]); end
          g = sign_r[i][j]; checks++;
          if (g !== want_r[k]) begin errors++; $display("FAIL signs%0d sign_r[%0d][%0d] got %0d want %0d", k, i, j, g, want_r[k]); end
          g = diff[i][j]; checks++;
          if (g !== 0) begin errors++; $display("FAIL signs%0d diff[%0d][%0d] got %0d want 0", k, i, j, g); end
        end
    end
  endtask

  task automatic test_saturation();
    integer g;
    int org_t [0:6];
    int rec_t [0:6];
    int want  [0:6];
    org_t = '{255, 0, 20, 4, 4, 19, 3};
    rec_t = '{0, 255, 4, 20, 21, 4, 19};
    want  = '{15, -16, 15, -16, -16, 15, -16};
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      fill_all(7, 7, rec_t[k], org_t[k]);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          g = diff[i][j]; checks++;
          if (g !== want[k]) begin
            errors++;
            $display("FAIL sat org=%0d rec=%0d diff[%0d][%0d] got %0d want %0d", org_t[k], rec_t[k], i, j, g, want[k]);
          end
        end
    end
  endtask

  task automatic test_independence();
    integer g;
    fill_all(128, 128, 128, 128);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        rec_m[i][j] = 8'(16 * i + j);
    model_block();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        g = sign_l[i][j]; checks++;
        if (g !== exp_sl[i][j]) begin errors++; $display("FAIL indep sign_l[%0d][%0d] got %0d want %0d", i, j, g, exp_sl[i][j]); end
        g = sign_r[i][j]; checks++;
        if (g !== exp_sr[i][j]) begin errors++; $display("FAIL indep sign_r[%0d][%0d] got %0d want %0d", i, j, g, exp_sr[i][j]); end
        g = diff[i][j]; checks++;
        if (g !== exp_df[i][j]) begin errors++; $display("FAIL indep diff[%0d][%0d] got %0d want %0d", i, j, g, exp_df[i][j]); end
      end
  endtask

  // Continuous valid stream of random blocks, then a bubble with data held.
  task automatic test_back_to_back(input int n);
    integer g;
    for (int k = 0; k <= n; k++) begin
      fill_random();
      in_valid = (k < n);
      if (k < n) model_block();
      tick();
      checks++;
      if (out_valid !== (k < n)) begin errors++; $display("FAIL b2b%0d out_valid got %b want %b", k, out_valid, (k < n)); end
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          g = sign_l[i][j]; checks++;
          if (g !== exp_sl[i][j]) begin errors++; $display("FAIL b2b%0d sign_l[%0d][%0d] got %0d want %0d", k, i, j, g, exp_sl[i][j]); end
          g = sign_r[i][j]; checks++;
          if (g !== exp_sr[i][j]) begin errors++; $display("FAIL b2b%0d sign_r[%0d][%0d] got %0d want %0d", k, i, j, g, exp_sr[i][j]); end
          g = diff[i][j]; checks++;
          if (g !== exp_df[i][j]) begin errors++; $display("FAIL b2b%0d diff[%0d][%0d] got %0d want %0d", k, i, j, g, exp_df[i][j]); end
        end
    end
  endtask

  task automatic test_reset_midstream();
    integer g;
    in_valid = 1'b1;
    fill_random();
    tick();
    fill_all(1, 2, 200, 30);
    rst_n = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst out_valid got %b want 0", out_valid); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        g = diff[i][j]; checks++;
        if (g !== 0) begin errors++; $display("FAIL midrst diff[%0d][%0d] got %0d want 0", i, j, g); end
        g = sign_l[i][j]; checks++;
        if (g !== 0) begin errors++; $display("FAIL midrst sign_l[%0d][%0d] got %0d want 0", i, j, g); end
      end
    rst_n = 1'b1;
    fill_random();
    model_block();
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL postrst out_valid got %b want 1", out_valid); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        g = sign_l[i][j]; checks++;
        if (g !== exp_sl[i][j]) begin errors++; $display("FAIL postrst sign_l[%0d][%0d] got %0d want %0d", i, j, g, exp_sl[i][j]); end
        g = sign_r[i][j]; checks++;
        if (g !== exp_sr[i][j]) begin errors++; $display("FAIL postrst sign_r[%0d][%0d] got %0d want %0d", i, j, g, exp_sr[i][j]); end
        g = diff[i][j]; checks++;
        if (g !== exp_df[i][j]) begin errors++; $display("FAIL postrst diff[%0d][%0d] got %0d want %0d", i, j, g, exp_df[i][j]); end
      end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    fill_all(0, 0, 0, 0);
    tick();
    tick();
    test_reset();
    test_uniform();
    test_signs();
    test_saturation();
    test_independence();
    test_back_to_back(3);
    test_back_to_back(40);
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sao_stat_one_block_4x4.md
# sao_stat_one_block_4x4

Per-sample statistics front end for HEVC Sample Adaptive Offset (SAO) encoder-side parameter estimation, operating on one 4x4 block per cycle. For each of 16 positions it produces two things from the reconstructed centre sample, its two neighbours along the chosen edge-offset direction, and the original sample. The first is the edge signs (centre vs. left neighbour, centre vs. right neighbour). The second is a saturated original-minus-reconstructed difference. Results feed the downstream SAO category/offset accumulators; direction selection and neighbour fetching happen upstream.

## Interface
Parameters:
- bit_depth, 8, sample width in bits.

Ports (arrays are unpacked [0:3][0:3], index [row][col]):
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  qualifies the input arrays this cycle.
- rec_l  input  bit_depth x16  reconstructed neighbour "a" (left along the EO direction).
- rec_r  input  bit_depth x16  reconstructed neighbour "b" (right along the EO direction).
- rec_m  input  bit_depth x16  reconstructed centre sample.
- org_m  input  bit_depth x16  original centre sample.
- out_valid  output  1  outputs hold a result for a valid input.
- sign_l  output  signed 2 x16  sign(rec_m − rec_l), in {−1, 0, +1}.
- sign_r  output  signed 2 x16  sign(rec_m − rec_r), in {−1, 0, +1}.
- diff  output  signed 5 x16  sat(org_m − rec_m) to [−16, +15].

## Operation
- All 16 positions are processed independently and identically. No cross-position interaction.
- Samples are unsigned. Compute differences at bit_depth+1 bits signed so no wrap occurs.
- sign_l:
  - +1 (2'b01) if rec_m > rec_l.
  - 0 (2'b00) if equal.
  - −1 (2'b11) if rec_m < rec_l.
  - The value 2'b10 is never produced.
- sign_r: same rule, using rec_r.
- diff:
  - d = org_m − rec_m, computed exactly (range −(2^bit_depth −1) … +(2^bit_depth −1)).
  - If d > 15, output +15.
  - If d < −16, output −16.
  - Otherwise output d.
- When in_valid=0, the output registers hold their previous values and out_valid goes to 0 next cycle.
- No internal accumulation; the block is stateless apart from the output pipeline register.

## Timing
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N with out_valid=1.
- Throughput: one 4x4 block per cycle. in_valid may be held high continuously, with no bubbles.
- Reset (rst_n=0 at a rising edge):
  - out_valid = 0.
  - All sign_l, sign_r and diff elements = 0.
  - Reset overrides in_valid in the same cycle.
  - A reset asserted mid-stream discards the in-flight block. The first output after reset deasserts comes from the first in_valid sampled with rst_n=1.
- No handshake back-pressure: there is no ready signal, and the consumer must accept every out_valid cycle.
- Purely combinational datapath between the input ports and the output register. No combinational path from inputs to outputs.

## Test plan
- Uniform block: all rec_l=222, rec_r=221, rec_m=223, org_m=225, in_valid=1. Next cycle, all 16 positions give sign_l=+1, sign_r=+1, diff=+2, out_valid=1.
- Signs negative/zero:
  - rec_m=100, rec_l=150, rec_r=100, org_m=100 → sign_l=−1 (2'b11), sign_r=0, diff=0.
  - Swap rec_l/rec_r per position and check symmetry.
- Saturation:
  - org_m=255, rec_m=0 → diff=+15.
  - org_m=0, rec_m=255 → diff=−16.
  - org_m=20, rec_m=4 → +15 (boundary d=16).
  - org_m=4, rec_m=20 → −16 (d=−16, exact).
  - org_m=4, rec_m=21 → −16 (saturated).
- Per-position independence: load rec_m[i][j]=16*i+j, all other inputs = 128. Each position's signs and diff match the per-element rule; no row/column swaps.
- Pipeline/valid:
  - Stream 3 distinct blocks back-to-back, then in_valid=0. Outputs appear in order, one cycle late, then out_valid=0 with data held.
- Reset: assert rst_n=0 while in_valid=1 with nonzero data. Next cycle, all outputs = 0 and out_valid=0; deassert and verify normal 1-cycle latency resumes.
